// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - register bus and receiver-side signals of uart_rx_ctrl
// slave is the controller; master is whoever drives the bus and models the receiver.
interface uart_rx_ctrl_if;
  logic        reg_we;
  logic        reg_re;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        irq;
  logic        rx_rst;
  logic [15:0] clk_div;
  logic [4:0]  bits_per_word;
  logic        parity_en;
  logic        parity_evan_odd;
  logic        two_stop_bit;
  logic [15:0] rx_data;
  logic        rx_new_data;
  logic        rx_frame_error;

  modport master (
    output reg_we, reg_re, reg_addr, reg_wdata, rx_data, rx_new_data, rx_frame_error,
    input  reg_rdata, irq, rx_rst, clk_div, bits_per_word, parity_en, parity_evan_odd,
           two_stop_bit
  );

  modport slave (
    input  reg_we, reg_re, reg_addr, reg_wdata, rx_data, rx_new_data, rx_frame_error,
    output reg_rdata, irq, rx_rst, clk_div, bits_per_word, parity_en, parity_evan_odd,
           two_stop_bit
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - uart_rx configuration, reset sequencing, receive FIFO and irq
// Four registers: CTRL, CLKDIV, DATA (pop on read), STATUS (sticky flags, W1C).
module uart_rx_ctrl #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 4096
) (
  input logic          clk,
  input logic          rst,
  uart_rx_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_DISABLED, S_RECONF, S_RUN} state_t;

  state_t       r_state, w_next;
  logic         r_rc_cnt;
  logic [15:0]  r_ctrl, r_clkdiv, r_rdata;
  logic [15:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]  r_level;
  logic [TW-1:0] r_to_cnt;
  logic         r_nd_prev, r_fe_prev;
  logic         r_ovr, r_ferr, r_to, r_irq;

  logic         w_run, w_rx_rst;
  logic         w_ctrl_wr, w_clkdiv_wr, w_stat_wr, w_flush;
  logic         w_empty, w_full, w_push_req, w_push, w_pop;
  logic         w_ovr_set, w_fe_set, w_to_set, w_lvl_hit;
  logic [8:0]   w_level9;
  logic [15:0]  w_status;

  assign w_ctrl_wr   = bus.reg_we && (bus.reg_addr == 2'd0);
  assign w_clkdiv_wr = bus.reg_we && (bus.reg_addr == 2'd1);
  assign w_stat_wr   = bus.reg_we && (bus.reg_addr == 2'd3);
  assign w_flush     = w_ctrl_wr && bus.reg_wdata[9];

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == (AW+1)'(DEPTH));
  assign w_level9 = 9'(r_level);

  // Edge detect on the receiver's level strobes; only RUN accepts them.
  assign w_push_req = bus.rx_new_data && !r_nd_prev && w_run && !w_flush;
  assign w_pop      = bus.reg_re && (bus.reg_addr == 2'd2) && !w_empty;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovr_set  = w_push_req && w_full && !w_pop;
  assign w_fe_set   = bus.rx_frame_error && !r_fe_prev && w_run;
  assign w_to_set   = (r_to_cnt == TW'(TIMEOUT));
  assign w_lvl_hit  = (r_ctrl[13:10] != 4'd0) && (w_level9 >= {5'd0, r_ctrl[13:10]});

  assign w_status = {1'b0, w_rx_rst, r_to, r_ferr, r_ovr, w_full, w_empty, w_level9};

  // Sequencer: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_DISABLED;
      r_rc_cnt <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rc_cnt <= (r_state == S_RECONF) && !r_rc_cnt;
    end
  end

  // Sequencer: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_DISABLED: if (w_ctrl_wr && bus.reg_wdata[0]) w_next = S_RECONF;
      S_RECONF:   if (r_rc_cnt) w_next = r_ctrl[0] ? S_RUN : S_DISABLED;
      S_RUN: begin
        if (w_ctrl_wr && !bus.reg_wdata[0])  w_next = S_DISABLED;
        else if (w_ctrl_wr || w_clkdiv_wr)   w_next = S_RECONF;
      end
      default:    w_next = S_DISABLED;
    endcase
  end

  // Sequencer: outputs
  always_comb begin
    w_run    = 1'b0;
    w_rx_rst = 1'b1;
    if (r_state == S_RUN) begin
      w_run    = 1'b1;
      w_rx_rst = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl   <= 16'd0;
      r_clkdiv <= 16'd1;
    end else begin
      if (w_ctrl_wr)   r_ctrl   <= bus.reg_wdata & 16'h7DFF;
      if (w_clkdiv_wr) r_clkdiv <= bus.reg_wdata;
    end
  end

  // When full, push and pop share a slot: the old head is read out before the overwrite.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (w_pop && !w_push) r_level <= r_level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nd_prev <= 1'b0;
      r_fe_prev <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_nd_prev <= bus.rx_new_data;
      r_fe_prev <= bus.rx_frame_error;
      if (w_push || w_pop || w_empty) r_to_cnt <= '0;
      else if (!w_to_set)             r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_to   <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set || (r_ovr  && !(w_stat_wr && bus.reg_wdata[11]));
      r_ferr <= w_fe_set  || (r_ferr && !(w_stat_wr && bus.reg_wdata[12]));
      r_to   <= w_to_set  || (r_to   && !(w_stat_wr && bus.reg_wdata[13]));
      r_irq  <= r_ctrl[14] && (w_lvl_hit || r_to || r_ovr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 16'd0;
    end else if (bus.reg_re) begin
      case (bus.reg_addr)
        2'd0:    r_rdata <= r_ctrl;
        2'd1:    r_rdata <= r_clkdiv;
        2'd2:    r_rdata <= w_empty ? 16'd0 : r_mem[r_rptr];
        default: r_rdata <= w_status;
      endcase
    end
  end

  assign bus.reg_rdata       = r_rdata;
  assign bus.irq             = r_irq;
  assign bus.rx_rst          = w_rx_rst;
  assign bus.clk_div         = r_clkdiv;
  assign bus.bits_per_word   = r_ctrl[5:1];
  assign bus.parity_en       = r_ctrl[6];
  assign bus.parity_evan_odd = r_ctrl[7];
  assign bus.two_stop_bit    = r_ctrl[8];
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
// Pushed words go to a scoreboard queue; DATA reads pop and compare.
module tb_uart_rx_ctrl;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if u_if ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb[$];
  logic [15:0] v;
  logic [15:0] exp_w;
  int          lat;
  logic        fired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [15:0] data);
    u_if.reg_we    = 1'b1;
    u_if.reg_addr  = addr;
    u_if.reg_wdata = data;
    tick();
    u_if.reg_we    = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [15:0] data);
    u_if.reg_re   = 1'b1;
    u_if.reg_addr = addr;
    tick();
    u_if.reg_re   = 1'b0;
    data = u_if.reg_rdata;
  endtask

  task automatic push_word(input logic [15:0] d);
    u_if.rx_data     = d;
    u_if.rx_new_data = 1'b1;
    tick();
    u_if.rx_new_data = 1'b0;
    tick();
    if (sb.size() < DEPTH) sb.push_back(d);
  endtask

  task automatic read_data(input string tag);
    logic [15:0] got;
    logic [15:0] exp;
    reg_read(2'd2, got);
    exp = (sb.size() > 0) ? sb.pop_front() : 16'd0;
    check(tag, got, exp);
  endtask

  task automatic status_is(input string tag, input logic [15:0] exp);
    logic [15:0] got;
    reg_read(2'd3, got);
    check(tag, got, exp);
  endtask

  initial begin
    u_if.reg_we = 0; u_if.reg_re = 0; u_if.reg_addr = 0; u_if.reg_wdata = 0;
    u_if.rx_data = 0; u_if.rx_new_data = 0; u_if.rx_frame_error = 0;
    repeat (3) tick();
    check("rst_irq", u_if.irq, 0);
    check("rst_rx_rst", u_if.rx_rst, 1);
    check("rst_clk_div", u_if.clk_div, 16'd1);
    check("rst_rdata", u_if.reg_rdata, 0);
    rst = 1'b1;
    tick();
    status_is("rst_status", 16'h4200);

    // Configure and enable: two cycles of receiver reset, then RUN
    reg_write(2'd1, 16'h0010);
    check("clk_div", u_if.clk_div, 16'h0010);
    check("dis_rx_rst", u_if.rx_rst, 1);
    reg_write(2'd0, 16'h0011);
    check("reconf_c1", u_if.rx_rst, 1);
    tick();
    check("reconf_c2", u_if.rx_rst, 1);
    tick();
    check("run_rx_rst", u_if.rx_rst, 0);
    check("bpw", u_if.bits_per_word, 5'd8);

    // A long new_data level yields a single push
    u_if.rx_data = 16'h00A5;
    u_if.rx_new_data = 1'b1;
    repeat (40) tick();
    u_if.rx_new_data = 1'b0;
    tick();
    sb.push_back(16'h00A5);
    status_is("hold_level1", 16'h0001);
    read_data("data_a5");
    status_is("after_pop", 16'h0200);
    read_data("data_empty");
    status_is("empty_stays", 16'h0200);

    // Overflow: 17 pushes, 16 kept
    for (int i = 0; i <= DEPTH; i++) push_word(16'(i));
    status_is("full_ovr", 16'h0C10);
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("ovr_rd%0d", i));
    status_is("drained_ovr", 16'h0A00);
    reg_write(2'd3, 16'h0800);
    status_is("ovr_clr", 16'h0200);

    u_if.rx_frame_error = 1'b1;
    tick();
    u_if.rx_frame_error = 1'b0;
    tick();
    status_is("ferr", 16'h1200);
    reg_write(2'd3, 16'h1000);
    status_is("ferr_clr", 16'h0200);

    // Full FIFO with coincident push and pop
    for (int i = 0; i < DEPTH; i++) push_word(16'h0100 + 16'(i));
    exp_w = sb.pop_front();
    sb.push_back(16'h01FF);
    u_if.rx_data = 16'h01FF;
    u_if.rx_new_data = 1'b1;
    u_if.reg_re = 1'b1;
    u_if.reg_addr = 2'd2;
    tick();
    u_if.reg_re = 1'b0;
    u_if.rx_new_data = 1'b0;
    check("pushpop_head", u_if.reg_rdata, exp_w);
    tick();
    status_is("pushpop_full", 16'h0410);
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("pp_rd%0d", i));

    // Level threshold interrupt
    reg_write(2'd0, 16'h5011);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) push_word(16'h0200 + 16'(i));
    check("irq_below_thr", u_if.irq, 0);
    u_if.rx_data = 16'h0203;
    u_if.rx_new_data = 1'b1;
    tick();
    check("irq_delay", u_if.irq, 0);
    u_if.rx_new_data = 1'b0;
    tick();
    check("irq_thr", u_if.irq, 1);
    sb.push_back(16'h0203);
    for (int i = 0; i < 4; i++) read_data($sformatf("thr_rd%0d", i));
    tick();
    check("irq_thr_gone", u_if.irq, 0);

    // Idle timeout
    push_word(16'h0055);
    fired = 1'b0;
    lat = 0;
    for (int n = 1; n <= TIMEOUT + 50; n++) begin
      tick();
      if (u_if.irq) begin
        fired = 1'b1;
        lat = n;
        break;
      end
    end
    check("to_fired", fired, 1);
    check("to_not_early", (lat >= TIMEOUT), 1);
    status_is("to_status", 16'h2001);
    read_data("to_data");
    reg_write(2'd3, 16'h2000);
    status_is("to_clr", 16'h0200);
    check("to_irq_gone", u_if.irq, 0);

    // Flush with a coincident push
    push_word(16'h0061);
    push_word(16'h0062);
    u_if.reg_we = 1'b1;
    u_if.reg_addr = 2'd0;
    u_if.reg_wdata = 16'h0211;
    u_if.rx_data = 16'h0077;
    u_if.rx_new_data = 1'b1;
    tick();
    u_if.reg_we = 1'b0;
    u_if.rx_new_data = 1'b0;
    sb.delete();
    repeat (3) tick();
    status_is("flush_level", 16'h0200);
    reg_read(2'd0, v);
    check("ctrl_no_flush", v, 16'h0011);
    read_data("flush_empty");

    // Async reset mid-RUN with words buffered
    for (int i = 0; i < 3; i++) push_word(16'h0300 + 16'(i));
    reg_read(2'd0, v);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_rx_rst", u_if.rx_rst, 1);
    check("arst_irq", u_if.irq, 0);
    check("arst_clk_div", u_if.clk_div, 16'd1);
    check("arst_bpw", u_if.bits_per_word, 5'd0);
    check("arst_rdata", u_if.reg_rdata, 0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    status_is("arst_status", 16'h4200);
    read_data("arst_data");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
